// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: main control FSM of the multicycle RV32I core.
// Sequences the shared ALU, memory port, IR and extend unit for lw/sw/R/I.
//
// Ports:
//   clk, rst_n (sync, active-low)
//   op, funct3, funct7b5 : instruction fields from the IR
//   mem_ready            : memory port finished the access this cycle
//   mem_req, adr_src, ir_write, pc_write, mem_write, reg_write, immsrc
//   alu_src_a, alu_src_b, result_src, alu_control : datapath selects
//   instr_done           : one-cycle retire pulse
//   illegal              : sticky illegal-opcode flag
//
// Optional feature: define RISCV_CTRL_ILLEGAL_TRAP_EN to trap unknown
// opcodes in TRAP (sets illegal). Otherwise they retire as a NOP.
module riscv_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       immsrc,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    ,
    S_TRAP
`endif
  } state_e;

  state_e state_q, state_d;
  state_e cur;

  function automatic logic [2:0] alu_dec(
    input logic [6:0] op_i,
    input logic [2:0] f3,
    input logic       f7b5
  );
    logic [2:0] r;
    case (f3)
      3'b000:  r = (op_i == OP_R && f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  r = ALU_SLT;
      3'b110:  r = ALU_OR;
      3'b111:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    // While reset is held, present the FETCH decode so the
    // memory address mux is already pointing at the PC.
    cur         = rst_n ? state_q : S_FETCH;
    state_d     = cur;
    mem_req     = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    immsrc      = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = ALU_ADD;
    instr_done  = 1'b0;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    unique case (cur)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready & rst_n;
        pc_write   = mem_ready & rst_n;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          default: begin
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
            state_d   = S_TRAP;
            illegal_d = 1'b1;
`else
            state_d    = S_FETCH;
            instr_done = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        immsrc    = (op == OP_SW);
        state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = alu_dec(op, funct3, funct7b5);
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec(op, funct3, funct7b5);
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        state_d = S_TRAP;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl: scoreboard bench for the multicycle control FSM.
// Expected per-cycle output vectors are queued with their mem_ready stimulus.
module tb_riscv_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       mem_ready;
  logic       mem_req;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       mem_write;
  logic       reg_write;
  logic       immsrc;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] alu_control;
  logic       instr_done;
  logic       illegal;

  int checks;
  int failures;

  typedef struct packed {
    logic        rdy;
    logic [17:0] vec;
  } ent_t;

  ent_t  exp_q[$];
  string tag_q[$];

  riscv_multicycle_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .op(op),
    .funct3(funct3),
    .funct7b5(funct7b5),
    .mem_ready(mem_ready),
    .mem_req(mem_req),
    .adr_src(adr_src),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .mem_write(mem_write),
    .reg_write(reg_write),
    .immsrc(immsrc),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .result_src(result_src),
    .alu_control(alu_control),
    .instr_done(instr_done),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [17:0] got,
                       input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] v(
    input logic mr, ad, ir, pc, mw, rw, im,
    input logic [1:0] a, b, rs,
    input logic [2:0] al,
    input logic dn, il
  );
    return {mr, ad, ir, pc, mw, rw, im, a, b, rs, al, dn, il};
  endfunction

  function automatic logic [2:0] alu_exp(input logic isr,
                                         input logic [2:0] f3,
                                         input logic f7);
    case (f3)
      3'b000:  return (isr && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic push(input logic rdy, input logic [17:0] vec,
                      input string tag);
    exp_q.push_back('{rdy: rdy, vec: vec});
    tag_q.push_back(tag);
  endtask

  // Invariant: each iteration starts just after a rising edge.
  task automatic run_q();
    ent_t  e;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      mem_ready = e.rdy;
      @(negedge clk);
      check(t,
            {mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
             immsrc, alu_src_a, alu_src_b, result_src, alu_control,
             instr_done, illegal},
            e.vec);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
  endtask

  task automatic p_fetch(input int nwait);
    for (int i = 0; i < nwait; i++)
      push(1'b0, v(1,0,0,0,0,0,0,2'b00,2'b10,2'b10,3'b000,0,0),
           "fetch_wait");
    push(1'b1, v(1,0,1,1,0,0,0,2'b00,2'b10,2'b10,3'b000,0,0), "fetch");
  endtask

  task automatic p_decode(input logic done);
    push(1'b1, v(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b000,done,0),
         "decode");
  endtask

  task automatic p_lw(input int fw, input int mw);
    set_instr(7'b0000011, 3'b010, 1'b0);
    p_fetch(fw);
    p_decode(1'b0);
    push(1'b1, v(0,0,0,0,0,0,0,2'b10,2'b01,2'b00,3'b000,0,0), "lw_memadr");
    for (int i = 0; i < mw; i++)
      push(1'b0, v(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0),
           "lw_memread_wait");
    push(1'b1, v(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0),
         "lw_memread");
    push(1'b1, v(0,0,0,0,0,1,0,2'b00,2'b00,2'b01,3'b000,1,0), "lw_memwb");
    run_q();
  endtask

  task automatic p_sw(input int mw);
    set_instr(7'b0100011, 3'b010, 1'b0);
    p_fetch(0);
    p_decode(1'b0);
    push(1'b1, v(0,0,0,0,0,0,1,2'b10,2'b01,2'b00,3'b000,0,0), "sw_memadr");
    for (int i = 0; i < mw; i++)
      push(1'b0, v(1,1,0,0,1,0,0,2'b00,2'b00,2'b00,3'b000,0,0),
           "sw_memwrite_wait");
    push(1'b1, v(1,1,0,0,1,0,0,2'b00,2'b00,2'b00,3'b000,1,0),
         "sw_memwrite");
    run_q();
  endtask

  task automatic p_alu(input logic isr, input logic [2:0] f3,
                       input logic f7);
    set_instr(isr ? 7'b0110011 : 7'b0010011, f3, f7);
    p_fetch(0);
    p_decode(1'b0);
    push(1'b1, v(0,0,0,0,0,0,0,2'b10, isr ? 2'b00 : 2'b01, 2'b00,
                 alu_exp(isr, f3, f7), 0, 0),
         isr ? "execr" : "execi");
    push(1'b1, v(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000,1,0), "aluwb");
    run_q();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    set_instr(7'b0, 3'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, then FETCH with two wait cycles before lw.
    p_lw(2, 0);
    p_lw(0, 0);
    p_lw(0, 2);

    // Reset in the middle of a MEMREAD wait.
    set_instr(7'b0000011, 3'b010, 1'b0);
    p_fetch(0);
    p_decode(1'b0);
    push(1'b1, v(0,0,0,0,0,0,0,2'b10,2'b01,2'b00,3'b000,0,0), "lw_memadr");
    push(1'b0, v(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0),
         "lw_memread_wait");
    run_q();
    do_reset();
    push(1'b0, v(1,0,0,0,0,0,0,2'b00,2'b10,2'b10,3'b000,0,0),
         "post_reset_fetch");
    run_q();
    p_lw(0, 0);

    p_sw(3);
    p_sw(0);

    p_alu(1'b1, 3'b000, 1'b1);
    p_alu(1'b0, 3'b000, 1'b1);
    p_alu(1'b0, 3'b111, 1'b0);
    p_alu(1'b1, 3'b000, 1'b0);
    p_alu(1'b1, 3'b010, 1'b0);
    p_alu(1'b1, 3'b110, 1'b1);
    p_alu(1'b1, 3'b001, 1'b0);
    p_alu(1'b0, 3'b010, 1'b0);

    // Unknown opcode.
    set_instr(7'b1111111, 3'b000, 1'b0);
    p_fetch(0);
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
    p_decode(1'b0);
    for (int i = 0; i < 3; i++)
      push(1'b1, v(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,1), "trap");
    run_q();
    do_reset();
    p_fetch(1);
    run_q();
`else
    p_decode(1'b1);
    run_q();
    p_alu(1'b1, 3'b111, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Main control FSM for the multicycle RV32I core. It sequences one shared ALU, one shared memory port, the instruction register and the extend unit through fetch, decode, execute, memory and writeback. It supports lw, sw, R-type ALU and I-type ALU instructions. It drives the extend unit's 1-bit `immsrc` select: 0 selects the I-format immediate, 1 selects the S-format immediate.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- mem_ready  in  1  memory port completed the access this cycle
- mem_req  out  1  memory access request
- adr_src  out  1  0 = PC, 1 = ALU result register
- ir_write  out  1  load the instruction register
- pc_write  out  1  load the PC
- mem_write  out  1  store strobe
- reg_write  out  1  register file write enable
- immsrc  out  1  extend unit select (0 = I-format, 1 = S-format)
- alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1 register
- alu_src_b  out  2  00 = rs2 register, 01 = immext, 10 = constant 4
- result_src  out  2  00 = ALU out register, 01 = memory data register, 10 = ALU result
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  sticky illegal-opcode flag (only with the macro; tied 0 otherwise)

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, TRAP.
- Unless listed for a state, every output is 0 and `alu_control` is 000.
- **FETCH**
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, add.
  - ir_write and pc_write equal mem_ready (Mealy).
  - Stays in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
- **DECODE**
  - alu_src_a=01, alu_src_b=01, immsrc=0, add.
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - any other op → see Configuration
- **MEMADR**
  - alu_src_a=10, alu_src_b=01, add.
  - immsrc=1 if op=0100011, else 0.
  - Next state: MEMWRITE for sw, MEMREAD for lw.
- **MEMREAD**
  - mem_req=1, adr_src=1.
  - Waits while mem_ready=0; moves to MEMWB when mem_ready=1.
- **MEMWB**
  - result_src=01, reg_write=1, instr_done=1.
  - Next state: FETCH.
- **MEMWRITE**
  - mem_req=1, adr_src=1, mem_write=1.
  - Stays while mem_ready=0.
  - When mem_ready=1: instr_done=1, next state FETCH.
- **EXECR**
  - alu_src_a=10, alu_src_b=00, function decode.
  - Next state: ALUWB.
- **EXECI**
  - alu_src_a=10, alu_src_b=01, immsrc=0, function decode.
  - Next state: ALUWB.
- **ALUWB**
  - result_src=00, reg_write=1, instr_done=1.
  - Next state: FETCH.
- **Function decode** (EXECR and EXECI only):
  - funct3 000 → sub only when op=0110011 and funct7b5=1; otherwise add.
  - funct3 010 → slt.
  - funct3 110 → or.
  - funct3 111 → and.
  - Any other funct3 → add.
- `op` is sampled only in DECODE, MEMADR, EXECR and EXECI. The instruction register is stable from the cycle after FETCH completes.

## Timing
- rst_n low at a rising edge: state becomes FETCH and `illegal` clears. This applies mid-instruction too, including during a memory wait. The aborted instruction does not retire.
- During the reset cycle all outputs are 0, except the FETCH combinational values held while rst_n is low.
- Minimum latency with mem_ready held 1, FETCH to retire:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and I-type: 4 cycles
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Handshake rules:
  - mem_req stays asserted, with a stable address select, until the cycle mem_ready=1.
  - mem_ready is ignored in every other state.
  - mem_write is never asserted outside MEMWRITE.
- instr_done is high for exactly one cycle per retired instruction. It is never high in FETCH.

## Configuration
- `RISCV_CTRL_ILLEGAL_TRAP_EN` defined:
  - An unknown op in DECODE moves to TRAP and sets `illegal`=1.
  - TRAP holds, with all write enables 0, until reset.
- Macro undefined:
  - An unknown op in DECODE retires as a NOP: instr_done=1 in DECODE, next state FETCH.
  - `illegal` is tied 0 and the TRAP state is not built.

## Test plan
- Reset mid-MEMREAD (rst_n=0 for one edge) → next cycle is FETCH with mem_req=1, adr_src=0, and no reg_write or instr_done.
- lw (op=0000011) with mem_ready=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. immsrc=0 in MEMADR, reg_write=1 only in MEMWB, 5 cycles total.
- sw (op=0100011), mem_ready held 0 for 3 cycles in MEMWRITE → immsrc=1 in MEMADR, mem_write held 4 cycles, instr_done in the last of them, retires in 7 cycles.
- R-type with funct3=000 and funct7b5=1 → alu_control=001 in EXECR. The same fields with op=0010011 → 000. I-type funct3=111 → 010.
- FETCH with mem_ready low for 2 cycles → ir_write and pc_write stay 0 until the third cycle, then pulse once.
- op=1111111:
  - With the macro: TRAP, illegal=1, and no further mem_req.
  - Without the macro: instr_done in DECODE, then FETCH.
